// File: rtl/pic_priority_resolver_if.sv
// Interface bundling the resolver's request/acknowledge/status signals.
// The master side is the control logic and IR pins; the slave side is the resolver.
interface pic_priority_resolver_if;
    logic [7:0] IR;
    logic [7:0] IM;
    logic       LTIM;
    logic       AEOI;
    logic [7:0] OCW2;
    logic       ocw2_wr;
    logic       first_ACK;
    logic       second_ACK;
    logic       INT;
    logic [2:0] INT_VEC;
    logic [7:0] IRR;
    logic [7:0] ISR;

    modport master (
        output IR, IM, LTIM, AEOI, OCW2, ocw2_wr, first_ACK, second_ACK,
        input  INT, INT_VEC, IRR, ISR
    );

    modport slave (
        input  IR, IM, LTIM, AEOI, OCW2, ocw2_wr, first_ACK, second_ACK,
        output INT, INT_VEC, IRR, ISR
    );
endinterface

// File: rtl/pic_priority_resolver.sv
// 8259A interrupt-request / in-service stage: holds IRR and ISR, resolves
// fully nested priority with an optional rotating lowest-priority pointer,
// and drives INT plus the winning level latched on the ACK1 rising edge.
// Optional feature macro: PIC_ROTATION_EN (rotation commands and AEOI rotation).
// Without it the lowest-priority pointer stays at LOW_PRI_RST.
module pic_priority_resolver #(
    parameter int         NUM_IR      = 8,
    parameter logic [2:0] LOW_PRI_RST = 3'd7
) (
    input logic                  clk,
    input logic                  rst,
    pic_priority_resolver_if.slave bus
);

    logic [NUM_IR-1:0] irr, irr_n;
    logic [NUM_IR-1:0] isr, isr_n;
    logic [NUM_IR-1:0] ir_q;
    logic              int_q, int_n;
    logic [2:0]        int_vec, vec_n;
    logic              ack1_q, ack2_q;
    logic [2:0]        low_pri;

`ifdef PIC_ROTATION_EN
    logic [2:0]        low_pri_n;
    logic              rot_aeoi, rot_aeoi_n;
`else
    // Fixed priority: IR(LOW_PRI_RST+1) highest, rotation in AEOI never enabled
    assign low_pri = LOW_PRI_RST;
`endif

    logic [NUM_IR-1:0] cand;
    logic              cand_any, isr_any;
    logic [2:0]        winner, isr_top;
    logic              ack1_rise, ack2_fall;
    logic [2:0]        ocw2_code, ocw2_lvl;
    logic              unused_ocw2;

    // Highest-priority set bit of v, scanning from lp+1 and wrapping down to lp
    function automatic logic [2:0] first_set(input logic [NUM_IR-1:0] v, input logic [2:0] lp);
        logic [2:0] idx;
        logic       found;
        first_set = 3'd0;
        found     = 1'b0;
        for (int k = 1; k <= NUM_IR; k++) begin
            idx = lp + 3'(k);
            if (!found && v[idx]) begin
                first_set = idx;
                found     = 1'b1;
            end
        end
    endfunction

    // Priority rank of level i, 0 is highest, under pointer lp
    function automatic logic [2:0] rank(input logic [2:0] i, input logic [2:0] lp);
        rank = i - lp - 3'd1;
    endfunction

    assign cand        = irr & ~bus.IM;
    assign cand_any    = |cand;
    assign isr_any     = |isr;
    assign winner      = first_set(cand, low_pri);
    assign isr_top     = first_set(isr, low_pri);
    assign ack1_rise   = bus.first_ACK & ~ack1_q;
    assign ack2_fall   = ~bus.second_ACK & ack2_q;
    assign ocw2_code   = bus.OCW2[7:5];
    assign ocw2_lvl    = bus.OCW2[2:0];
    assign unused_ocw2 = ^bus.OCW2[4:3];

    // Next-state for IRR, ISR, INT, vector and the rotation state
    always_comb begin
        irr_n = irr;
        isr_n = isr;
        vec_n = int_vec;
`ifdef PIC_ROTATION_EN
        low_pri_n  = low_pri;
        rot_aeoi_n = rot_aeoi;
`endif

        int_n = cand_any && (!isr_any || (rank(winner, low_pri) < rank(isr_top, low_pri)));

        if (bus.LTIM) begin
            irr_n = bus.IR;
        end else begin
            irr_n = (irr & bus.IR) | (bus.IR & ~ir_q);
            if (ack1_rise && cand_any)
                irr_n[winner] = 1'b0;
        end

        if (ack2_fall && bus.AEOI) begin
            isr_n[int_vec] = 1'b0;
`ifdef PIC_ROTATION_EN
            if (rot_aeoi)
                low_pri_n = int_vec;
`endif
        end

        if (bus.ocw2_wr) begin
            case (ocw2_code)
                3'b001, 3'b101: begin
                    if (isr_any) begin
                        isr_n[isr_top] = 1'b0;
`ifdef PIC_ROTATION_EN
                        if (ocw2_code[2])
                            low_pri_n = isr_top;
`endif
                    end
                end
                3'b011, 3'b111: begin
                    isr_n[ocw2_lvl] = 1'b0;
`ifdef PIC_ROTATION_EN
                    if (ocw2_code[2])
                        low_pri_n = ocw2_lvl;
`endif
                end
`ifdef PIC_ROTATION_EN
                3'b110: low_pri_n  = ocw2_lvl;
                3'b100: rot_aeoi_n = 1'b1;
                3'b000: rot_aeoi_n = 1'b0;
`endif
                default: ;
            endcase
        end

        // ACK1 set is applied last so it wins over a same-cycle EOI on that bit
        if (ack1_rise) begin
            if (cand_any) begin
                vec_n         = winner;
                isr_n[winner] = 1'b1;
            end else begin
                vec_n = 3'd7;
            end
        end
    end

    // Core state registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            irr     <= '0;
            isr     <= '0;
            ir_q    <= '0;
            int_q   <= 1'b0;
            int_vec <= 3'd0;
            ack1_q  <= 1'b0;
            ack2_q  <= 1'b0;
        end else begin
            irr     <= irr_n;
            isr     <= isr_n;
            ir_q    <= bus.IR;
            int_q   <= int_n;
            int_vec <= vec_n;
            ack1_q  <= bus.first_ACK;
            ack2_q  <= bus.second_ACK;
        end
    end

`ifdef PIC_ROTATION_EN
    // Rotating priority pointer and rotate-in-AEOI flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            low_pri  <= LOW_PRI_RST;
            rot_aeoi <= 1'b0;
        end else begin
            low_pri  <= low_pri_n;
            rot_aeoi <= rot_aeoi_n;
        end
    end
`endif

    assign bus.INT     = int_q;
    assign bus.INT_VEC = int_vec;
    assign bus.IRR     = irr;
    assign bus.ISR     = isr;

endmodule

// File: tb/tb_pic_priority_resolver.sv
// Directed self-checking bench for pic_priority_resolver.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_pic_priority_resolver;

    logic clk;
    logic rst;
    int   tests_run;
    int   tests_failed;

    pic_priority_resolver_if bus();

    pic_priority_resolver dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Free-running clock, period 10
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance n rising edges, landing just after the last one
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drive the IR pins and let the given number of edges pass
    task automatic applyStimulus(input logic [7:0] ir, input int cycles);
        bus.IR = ir;
        tick(cycles);
    endtask

    // One-cycle OCW2 write
    task automatic writeOcw2(input logic [7:0] val);
        bus.OCW2    = val;
        bus.ocw2_wr = 1'b1;
        tick(1);
        bus.ocw2_wr = 1'b0;
        bus.OCW2    = 8'h00;
    endtask

    // One-cycle ACK1 pulse
    task automatic pulseAck1;
        bus.first_ACK = 1'b1;
        tick(1);
        bus.first_ACK = 1'b0;
    endtask

    task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        tests_run++;
        assert (observed === expected)
        else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed %02h expected %02h", tag, observed, expected);
        end
    endtask

    logic [2:0] rot_vec1;
    logic [2:0] rot_vec2;

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst            = 1'b1;
        bus.IR         = 8'h00;
        bus.IM         = 8'h00;
        bus.LTIM       = 1'b0;
        bus.AEOI       = 1'b0;
        bus.OCW2       = 8'h00;
        bus.ocw2_wr    = 1'b0;
        bus.first_ACK  = 1'b0;
        bus.second_ACK = 1'b0;
        tick(3);
        checkOutput("rst_int", {7'd0, bus.INT}, 8'h00);
        checkOutput("rst_vec", {5'd0, bus.INT_VEC}, 8'h00);
        checkOutput("rst_irr", bus.IRR, 8'h00);
        checkOutput("rst_isr", bus.ISR, 8'h00);
        rst = 1'b0;
        tick(2);

        // Edge-triggered request on IR2 and its acknowledge
        applyStimulus(8'h04, 1);
        checkOutput("edge_irr", bus.IRR, 8'h04);
        checkOutput("edge_int_early", {7'd0, bus.INT}, 8'h00);
        tick(1);
        checkOutput("edge_int", {7'd0, bus.INT}, 8'h01);
        pulseAck1();
        checkOutput("ack_vec2", {5'd0, bus.INT_VEC}, 8'h02);
        checkOutput("ack_isr2", bus.ISR, 8'h04);
        checkOutput("ack_irr_clr", bus.IRR, 8'h00);
        tick(1);
        checkOutput("ack_int_drop", {7'd0, bus.INT}, 8'h00);

        // Nesting: IR0 preempts IR2 in service
        applyStimulus(8'h05, 2);
        checkOutput("nest_hi_int", {7'd0, bus.INT}, 8'h01);
        applyStimulus(8'h04, 2);
        checkOutput("nest_hi_gone", {7'd0, bus.INT}, 8'h00);
        // IR5 is lower priority than IR2 in service
        applyStimulus(8'h24, 2);
        checkOutput("nest_lo_irr", bus.IRR, 8'h20);
        checkOutput("nest_lo_int", {7'd0, bus.INT}, 8'h00);
        writeOcw2(8'h20);
        checkOutput("ns_eoi_isr", bus.ISR, 8'h00);
        tick(1);
        checkOutput("ns_eoi_int", {7'd0, bus.INT}, 8'h01);
        pulseAck1();
        checkOutput("ack_vec5", {5'd0, bus.INT_VEC}, 8'h05);
        writeOcw2(8'h65);
        checkOutput("spec_eoi_isr", bus.ISR, 8'h00);
        applyStimulus(8'h00, 2);

        // Masked request is held in IRR but raises no INT
        bus.IM = 8'h01;
        applyStimulus(8'h01, 2);
        checkOutput("mask_irr", bus.IRR, 8'h01);
        checkOutput("mask_int", {7'd0, bus.INT}, 8'h00);
        bus.IM = 8'h00;
        tick(1);
        checkOutput("unmask_int", {7'd0, bus.INT}, 8'h01);
        pulseAck1();
        writeOcw2(8'h60);
        applyStimulus(8'h00, 2);

        // Automatic EOI across a full ACK1/ACK2 sequence
        bus.AEOI = 1'b1;
        applyStimulus(8'h08, 2);
        pulseAck1();
        checkOutput("aeoi_vec", {5'd0, bus.INT_VEC}, 8'h03);
        bus.second_ACK = 1'b1;
        tick(1);
        checkOutput("aeoi_isr_held", bus.ISR, 8'h08);
        bus.second_ACK = 1'b0;
        tick(1);
        checkOutput("aeoi_isr_clr", bus.ISR, 8'h00);
        bus.AEOI = 1'b0;
        applyStimulus(8'h00, 2);

        // Level mode: IRR follows IR and survives acknowledge
        bus.LTIM = 1'b1;
        applyStimulus(8'h40, 2);
        pulseAck1();
        checkOutput("lvl_vec", {5'd0, bus.INT_VEC}, 8'h06);
        checkOutput("lvl_irr_kept", bus.IRR, 8'h40);
        applyStimulus(8'h00, 1);
        checkOutput("lvl_irr_drop", bus.IRR, 8'h00);
        writeOcw2(8'h66);
        bus.LTIM = 1'b0;
        tick(1);

        // Set priority L=3 then rotate on non-specific EOI
`ifdef PIC_ROTATION_EN
        rot_vec1 = 3'd4;
        rot_vec2 = 3'd0;
`else
        rot_vec1 = 3'd0;
        rot_vec2 = 3'd4;
`endif
        writeOcw2(8'hC3);
        applyStimulus(8'h11, 2);
        checkOutput("rot_int", {7'd0, bus.INT}, 8'h01);
        pulseAck1();
        checkOutput("rot_vec1", {5'd0, bus.INT_VEC}, {5'd0, rot_vec1});
        tick(1);
        writeOcw2(8'hA0);
        checkOutput("rot_eoi_isr", bus.ISR, 8'h00);
        tick(1);
        pulseAck1();
        checkOutput("rot_vec2", {5'd0, bus.INT_VEC}, {5'd0, rot_vec2});
        writeOcw2({5'b01100, rot_vec2});
        writeOcw2(8'hC7);
        applyStimulus(8'h00, 2);

        // Spurious ACK1 returns 7 and leaves ISR alone
        applyStimulus(8'h02, 2);
        pulseAck1();
        checkOutput("pre_spur_isr", bus.ISR, 8'h02);
        applyStimulus(8'h00, 1);
        pulseAck1();
        checkOutput("spur_vec", {5'd0, bus.INT_VEC}, 8'h07);
        checkOutput("spur_isr", bus.ISR, 8'h02);

        // Reset in the middle of ACK2
        bus.AEOI       = 1'b1;
        bus.second_ACK = 1'b1;
        tick(1);
        rst = 1'b1;
        #1;
        checkOutput("midrst_int", {7'd0, bus.INT}, 8'h00);
        checkOutput("midrst_vec", {5'd0, bus.INT_VEC}, 8'h00);
        checkOutput("midrst_isr", bus.ISR, 8'h00);
        checkOutput("midrst_irr", bus.IRR, 8'h00);
        tick(1);
        rst            = 1'b0;
        bus.second_ACK = 1'b0;
        tick(2);
        checkOutput("post_rst_isr", bus.ISR, 8'h00);
        checkOutput("post_rst_int", {7'd0, bus.INT}, 8'h00);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/pic_priority_resolver.md
Name: pic_priority_resolver

Overview:
- Synchronous interrupt-request and in-service stage of the 8259A PIC. It sits between the IR pins and the control logic.
- Holds IRR and ISR and resolves priority (fully nested, with rotation). Drives INT to the CPU and the 3-bit winning level (INT_VEC) consumed by the control logic during the INTA sequence.
- Consumes from the control logic: IM, LTIM, AEOI, the OCW2 byte, and the first/second ACK state levels.

Parameters:
- NUM_IR, 8, number of interrupt lines (fixed at 8; vector width is 3).
- LOW_PRI_RST, 3'd7, reset value of the lowest-priority pointer (IR0 highest).

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  asynchronous, active-high reset
- IR  input  8  interrupt request lines, already synchronous to clk
- IM  input  8  interrupt mask, 1 = masked
- LTIM  input  1  1 = level-triggered, 0 = edge-triggered
- AEOI  input  1  automatic end of interrupt enabled
- OCW2  input  8  OCW2 byte: R/SL/EOI in [7:5], level L in [2:0]
- ocw2_wr  input  1  one-cycle strobe, OCW2 valid
- first_ACK  input  1  level, high while control logic is in ACK1
- second_ACK  input  1  level, high while control logic is in ACK2
- INT  output  1  interrupt request to CPU (registered)
- INT_VEC  output  3  level latched at ACK1 (registered)
- IRR  output  8  interrupt request register
- ISR  output  8  in-service register

Behaviour:
- Reset (async, rst=1): IRR=0, ISR=0, INT=0, INT_VEC=0, ir_q=0, low_pri=LOW_PRI_RST, ack1_q=ack2_q=0, rot_aeoi=0.
- Edge mode (LTIM=0): IRR[i] is set at an edge where IR[i]&~ir_q[i]. It is cleared when IR[i]=0 or when level i is acknowledged. Set wins over IR-low in the same cycle only if IR[i]=1.
- Level mode (LTIM=1): IRR[i] <= IR[i] every edge. Acknowledge does not clear it.
- Priority order starts at (low_pri+1) mod 8 and wraps downward to low_pri. Example: low_pri=7 gives 0 highest, 7 lowest; low_pri=3 gives 4 highest, 3 lowest.
- cand = IRR & ~IM. winner = highest-priority set bit of cand.
- INT <= 1 iff cand≠0 and winner has strictly higher priority than the highest set ISR bit (or ISR=0). Latency: IR rises before edge k → IRR set at k → INT=1 at k+1.
- ACK1 rising (first_ACK & ~ack1_q):
  - If cand≠0: INT_VEC<=winner; ISR[winner]<=1; edge mode also clears IRR[winner].
  - If cand=0 (spurious): INT_VEC<=3'd7 and ISR is unchanged.
- ACK2 falling (~second_ACK & ack2_q), AEOI=1: ISR[INT_VEC]<=0. If rot_aeoi=1, also low_pri<=INT_VEC.
- ocw2_wr=1, decoded by OCW2[7:5]:
  - 001 non-specific EOI: clear highest-priority ISR bit.
  - 011 specific EOI: clear ISR[L].
  - 101 rotate on non-specific EOI: clear highest ISR bit b; low_pri<=b.
  - 111 rotate on specific EOI: clear ISR[L]; low_pri<=L.
  - 110 set priority: low_pri<=L.
  - 100 set rotate-in-AEOI (rot_aeoi<=1); 000 clear rotate-in-AEOI.
  - 010 no-op.
  - EOI with ISR=0 is a no-op.
- Same-cycle ACK1 set and EOI clear: the EOI acts on the ISR value before the edge. The ACK1 set is applied afterwards and wins for the same bit. The priority pointer update from OCW2 takes effect the next cycle.
- INT and winner are recomputed every cycle. INT drops one cycle after ISR absorbs the winner, unless a higher-priority request is pending.
- Reset mid-INTA sequence: everything returns to reset values. A pending ACK2 falling edge after reset is ignored, because ack2_q=0.

Optional Feature:
- Macro PIC_ROTATION_EN.
- Defined: OCW2 codes 101, 111, 110, 100/000 and AEOI rotation behave as above.
- Undefined: low_pri is held at LOW_PRI_RST and rot_aeoi is held at 0. Codes 101 and 111 act as plain non-specific and specific EOI respectively; 110, 100 and 000 are no-ops.

Test Plan:
- LTIM=0, IM=0, IR=8'h04 at cycle 10 → IRR=8'h04 after edge 10, INT=1 after edge 11. ACK1 pulse → INT_VEC=2, ISR=8'h04, IRR=0, INT=0 next cycle.
- ISR=8'h04, then IR raises bit 0 → INT=1 (higher priority). IR raises bit 5 instead → INT stays 0. OCW2=8'h20 → ISR=0, INT=1 for bit 5.
- IM=8'h01, IR=8'h01 → IRR=8'h01, INT=0. Clear IM → INT=1 one cycle later.
- AEOI=1, IR=8'h08: full ACK1/ACK2 → INT_VEC=3, ISR=8'h08 during ACK2, ISR=0 after ACK2 falls.
- PIC_ROTATION_EN, OCW2=8'hC3 (set priority L=3), IR=8'h11 → ACK1 gives INT_VEC=4, then OCW2=8'hA0 → ISR=0, low_pri=4; next ACK1 gives INT_VEC=0.
- ACK1 with cand=0 → INT_VEC=7, ISR unchanged. Assert rst mid-ACK2 → all outputs 0, no ISR clear afterwards.
